matrix_key_scanner: RTL and testbench
=====================================

// Module: matrix_key_scanner
// PURPOSE
//   Parametrised row/column key-matrix scanner for the piano front end. Drives one-cold rows,
//   samples active-low columns, debounces every key, and emits press/release pulses.
//   Press events are queued into a key-code stream with a valid/ready handshake for the note logic.
//   Single clock domain: row timing comes from an internal enable count, not a derived clock.
// PARAMETERS
//   ROWS      4      number of matrix rows (>=2)
//   COLS      4      number of matrix columns (>=1)
//   SCAN_DIV  60000  clk_in cycles each row is driven (dwell); must be >=4
//   DEBOUNCE  4      consecutive per-key samples (one per frame) needed to change a key's state (>=1)
//   KEY_W     $clog2(ROWS*COLS)  key-code width (localparam-derived, not overridden)
// PORTS
//   clk_in     in   1          system clock
//   rst_n_in   in   1          synchronous active-low reset
//   col        in   COLS       column inputs, active low (0 = key closed on driven row)
//   row        out  ROWS       row drive, one-cold active low
//   key_state  out  ROWS*COLS  debounced state, bit r*COLS+c; 1 = released, 0 = pressed
//   key_press  out  ROWS*COLS  one-cycle pulse per key on debounced 1->0
//   key_release out ROWS*COLS  one-cycle pulse per key on debounced 0->1
//   key_code   out  KEY_W      index of queued pressed key
//   key_valid  out  1          key_code valid; held until accepted
//   key_ready  in   1          consumer accepts when key_valid & key_ready at clk edge
//   multi_key  out  1          1 when more than one key is debounced-pressed
// BEHAVIOUR
//   Reset (rst_n_in=0 at clk edge): row=~1 (row0 driven), row index 0, dwell cnt 0, col sync regs all 1,
//     key_state all 1, debounce counters 0, key_press/key_release 0, pending mask 0,
//     key_valid 0, key_code 0, multi_key 0. Reset mid-scan or mid-handshake discards everything.
//   Sync: col passes a 2-FF synchroniser (reset to all 1) before use.
//   Scan: cnt counts 0..SCAN_DIV-1 per row. On edge with cnt==SCAN_DIV-1 ("sample edge"): sample
//     synced col for current row r, cnt->0, r->(r+1) mod ROWS (ROWS-1 wraps to 0), row updates same edge.
//     Frame = ROWS*SCAN_DIV cycles; each key sampled once per frame.
//   Debounce per key k (row r): on its sample edge, if sample==key_state[k] counter->0; else counter+1,
//     and when counter reaches DEBOUNCE, key_state[k] takes the sample and counter->0 on that edge.
//     DEBOUNCE=1: state follows the first differing sample.
//   Pulses: key_press[k]/key_release[k] high exactly the one cycle after key_state[k] changes.
//     Several keys of one row may change on the same sample edge -> simultaneous pulses.
//   Queue: pending mask bit k set in the cycle key_press[k] is high (already-set bit merges, no error).
//     Output slot: when key_valid=0 or (key_valid & key_ready), load lowest-index pending bit next edge:
//     key_code=k, key_valid=1, clear bit k. None pending -> key_valid=0 after accept.
//     Accept and new press on same edge: press is recorded, accept clears slot, reload follows rule above.
//     While key_valid=1 & key_ready=0, key_code is stable. Releases never generate codes.
//   multi_key: registered, =1 the cycle after key_state holds >=2 zero bits, else 0.
//   Latency (press stable from frame sample n): key_state changes at sample n+DEBOUNCE-1,
//     key_press +1 cycle, key_valid +2 cycles (empty slot).
// TESTING  (ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3; frame=32 clk)
//   Reset, col=4'hF for 5 frames -> row cycles 1110,1101,1011,0111,1110 every 8 clk; key_state=16'hFFFF; no pulses/valid.
//   Hold key r1c2 (col[2]=0 while row[1]=0), ready=1 -> key_state[6]=0 after 3rd sample, one key_press[6] pulse,
//     key_code=6 key_valid for 1 cycle; release 3 frames -> one key_release[6], no code.
//   Bounce: r0c0 closed for 2 frames then open -> key_state unchanged, no pulses, no code.
//   r2c0 and r2c3 pressed together, ready=0 for 10 frames -> key_code=8 held valid; multi_key=1;
//     raise ready -> 8 accepted, then 11, then valid=0.
//   Assert rst_n_in mid-frame with key_valid=1 and key pressed -> all outputs at reset values next edge; rescan restarts row0.
//   Accept on same edge as new press of r3c1 -> no loss: code 13 delivered next.

Source files
------------

// File: rtl/matrix_key_scanner.sv
// Row/column key-matrix scanner: one-cold row drive, synchronised active-low columns,
// per-key debounce, press/release pulses and a valid/ready queue of pressed key codes.
module matrix_key_scanner #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 60000,
  parameter int unsigned DEBOUNCE = 4,
  localparam int unsigned KEY_W   = $clog2(ROWS * COLS)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [COLS-1:0]        col,
  output logic [ROWS-1:0]        row,
  output logic [ROWS*COLS-1:0]   key_state,
  output logic [ROWS*COLS-1:0]   key_press,
  output logic [ROWS*COLS-1:0]   key_release,
  output logic [KEY_W-1:0]       key_code,
  output logic                   key_valid,
  input  logic                   key_ready,
  output logic                   multi_key
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned RI_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0]  col_s1, col_s2;
  logic [CNT_W-1:0] cnt;
  logic [RI_W-1:0]  row_idx, row_idx_nxt;
  logic             sample_edge;
  logic [N-1:0]     state_q;
  logic [N-1:0]     pending, merged, pending_nxt;
  logic [N-1:0]     zeros;
  logic [KEY_W-1:0] load_idx;
  logic             load_hit, slot_free;
  logic [DB_W-1:0]  deb_cnt [N];

  // Dwell counter and row sequencing
  always_comb begin
    sample_edge = (cnt == CNT_W'(SCAN_DIV - 1));
    row_idx_nxt = (row_idx == RI_W'(ROWS - 1)) ? '0 : row_idx + RI_W'(1);
  end

  // Output slot: new presses merge into pending and are eligible for loading on this edge
  always_comb begin
    merged   = pending | key_press;
    load_hit = 1'b0;
    load_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (merged[i] && !load_hit) begin
        load_hit = 1'b1;
        load_idx = KEY_W'(i);
      end
    end
    slot_free   = !key_valid || key_ready;
    pending_nxt = merged;
    if (slot_free && load_hit) pending_nxt[load_idx] = 1'b0;
    zeros = ~key_state;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      col_s1      <= '1;
      col_s2      <= '1;
      cnt         <= '0;
      row_idx     <= '0;
      row         <= ~ROWS'(1);
      key_state   <= '1;
      state_q     <= '1;
      key_press   <= '0;
      key_release <= '0;
      pending     <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      multi_key   <= 1'b0;
      for (int k = 0; k < N; k++) deb_cnt[k] <= '0;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;

      if (sample_edge) begin
        cnt     <= '0;
        row_idx <= row_idx_nxt;
        row     <= ~(ROWS'(1) << row_idx_nxt);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Debounce only the keys of the row being sampled
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (sample_edge && (row_idx == RI_W'(r))) begin
            if (col_s2[c] == key_state[r*COLS+c]) begin
              deb_cnt[r*COLS+c] <= '0;
            end else if (deb_cnt[r*COLS+c] == DB_W'(DEBOUNCE - 1)) begin
              key_state[r*COLS+c] <= col_s2[c];
              deb_cnt[r*COLS+c]   <= '0;
            end else begin
              deb_cnt[r*COLS+c] <= deb_cnt[r*COLS+c] + DB_W'(1);
            end
          end
        end
      end

      state_q     <= key_state;
      key_press   <= state_q & ~key_state;
      key_release <= ~state_q & key_state;

      pending <= pending_nxt;
      if (slot_free) begin
        key_valid <= load_hit;
        if (load_hit) key_code <= load_idx;
      end

      // Two or more pressed keys: clearing the lowest zero bit leaves something
      multi_key <= |(zeros & (zeros - N'(1)));
    end
  end

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Directed bench for matrix_key_scanner: key-matrix model, pulse counters and a
// scoreboard of expected key codes compared on every accepted handshake.
module tb_matrix_key_scanner;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned NK   = ROWS * COLS;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [COLS-1:0] col;
  logic [ROWS-1:0] row;
  logic [NK-1:0]   key_state, key_press, key_release;
  logic [3:0]      key_code;
  logic            key_valid, key_ready, multi_key;

  logic [NK-1:0]   pressed;
  int              tests = 0;
  int              fails = 0;
  int              press_cnt [NK];
  int              rel_cnt [NK];
  int              total_press = 0;
  int              accept_cnt = 0;
  int              valid_cycles = 0;
  logic [3:0]      exp_q [$];

  matrix_key_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .col(col), .row(row),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .multi_key(multi_key)
  );

  always #5 clk_in = ~clk_in;

  // Switch matrix: a closed key pulls its column low while its row is driven
  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row[r] && pressed[r*COLS+c]) col[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rows(input string tag, input int n);
    logic [3:0] er;
    for (int j = 0; j < n; j++) begin
      repeat (j == 0 ? 4 : 8) @(negedge clk_in);
      er = ~(4'b0001 << (j % 4));
      check(tag, row, er);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row"}, row, 4'b1110);
    check({tag, "_state"}, key_state, 16'hFFFF);
    check({tag, "_press"}, key_press, 16'h0);
    check({tag, "_release"}, key_release, 16'h0);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_code"}, key_code, 4'h0);
    check({tag, "_multi"}, multi_key, 1'b0);
  endtask

  task automatic wait_row(input logic [3:0] target);
    int n;
    n = 0;
    while (row !== target && n < 64) begin
      @(negedge clk_in);
      n++;
    end
    check("wait_row", row, target);
  endtask

  // Monitor: pulse counting and scoreboard pop on every accepted code
  initial begin
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
    end
    forever begin
      @(negedge clk_in);
      #1;
      if (rst_n_in === 1'b1) begin
        for (int k = 0; k < NK; k++) begin
          if (key_press[k]) begin
            press_cnt[k]++;
            total_press++;
          end
          if (key_release[k]) rel_cnt[k]++;
        end
        if (key_valid) valid_cycles++;
        if (key_valid && key_ready) begin
          accept_cnt++;
          tests++;
          assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL sb_extra: observed code %0d, expected none", key_code);
          end
          if (exp_q.size() != 0) check("sb_code", key_code, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int v0, a0, n;
    rst_n_in  = 1'b0;
    key_ready = 1'b1;
    pressed   = '0;

    // Reset and idle scan
    repeat (3) @(negedge clk_in);
    check_reset_vals("t0_reset");
    rst_n_in = 1'b1;
    check_rows("t1_row_seq", 20);
    check("t1_state", key_state, 16'hFFFF);
    check("t1_no_press", total_press, 0);
    check("t1_no_valid", valid_cycles, 0);

    // Single press/release of r1c2
    wait_row(4'b1110);
    v0 = valid_cycles;
    pressed[6] = 1'b1;
    exp_q.push_back(4'd6);
    repeat (60) @(negedge clk_in);
    check("t2_debounce_wait", key_state[6], 1'b1);
    repeat (40) @(negedge clk_in);
    check("t2_pressed", key_state[6], 1'b0);
    check("t2_press_pulse", press_cnt[6], 1);
    check("t2_valid_one_cycle", valid_cycles - v0, 1);
    a0 = accept_cnt;
    pressed[6] = 1'b0;
    repeat (128) @(negedge clk_in);
    check("t2_released", key_state, 16'hFFFF);
    check("t2_release_pulse", rel_cnt[6], 1);
    check("t2_no_release_code", accept_cnt - a0, 0);

    // Bounce on r0c0: two frames closed is not enough
    wait_row(4'b1101);
    pressed[0] = 1'b1;
    repeat (66) @(negedge clk_in);
    pressed[0] = 1'b0;
    repeat (128) @(negedge clk_in);
    check("t3_state", key_state, 16'hFFFF);
    check("t3_no_press", press_cnt[0], 0);
    check("t3_no_code", accept_cnt - a0, 0);

    // Two keys in row 2 with consumer stalled
    key_ready = 1'b0;
    pressed[8]  = 1'b1;
    pressed[11] = 1'b1;
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd11);
    repeat (160) @(negedge clk_in);
    check("t4_valid_mid", key_valid, 1'b1);
    check("t4_code_mid", key_code, 4'd8);
    repeat (160) @(negedge clk_in);
    check("t4_valid_held", key_valid, 1'b1);
    check("t4_code_held", key_code, 4'd8);
    check("t4_multi", multi_key, 1'b1);
    check("t4_press8", press_cnt[8], 1);
    check("t4_press11", press_cnt[11], 1);
    a0 = accept_cnt;
    key_ready = 1'b1;
    repeat (5) @(negedge clk_in);
    check("t4_accepted", accept_cnt - a0, 2);
    check("t4_drained", key_valid, 1'b0);
    pressed[8]  = 1'b0;
    pressed[11] = 1'b0;
    repeat (128) @(negedge clk_in);
    check("t4_released", key_state, 16'hFFFF);
    check("t4_multi_clear", multi_key, 1'b0);

    // Reset mid-frame with a code held and a key down
    key_ready = 1'b0;
    pressed[5] = 1'b1;
    repeat (131) @(negedge clk_in);
    check("t5_valid_before", key_valid, 1'b1);
    check("t5_code_before", key_code, 4'd5);
    rst_n_in = 1'b0;
    pressed[5] = 1'b0;
    @(negedge clk_in);
    check_reset_vals("t5_reset");
    @(negedge clk_in);
    key_ready = 1'b1;
    rst_n_in  = 1'b1;
    check_rows("t5_rescan", 2);

    // Accept on the same edge as a new press of r3c1
    key_ready = 1'b0;
    pressed[4] = 1'b1;
    exp_q.push_back(4'd4);
    n = 0;
    while (!key_valid && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check("t6_wait_valid", key_valid, 1'b1);
    pressed[13] = 1'b1;
    exp_q.push_back(4'd13);
    n = 0;
    while (!key_press[13] && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check("t6_wait_press13", key_press[13], 1'b1);
    check("t6_slot_held", key_code, 4'd4);
    a0 = accept_cnt;
    key_ready = 1'b1;
    repeat (5) @(negedge clk_in);
    check("t6_both_accepted", accept_cnt - a0, 2);
    check("t6_drained", key_valid, 1'b0);
    check("t6_multi", multi_key, 1'b1);
    pressed = '0;
    repeat (128) @(negedge clk_in);
    check("t6_released", key_state, 16'hFFFF);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
